// File: rtl/sram_fifo_pkg.sv
// Shared defaults and state encoding for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

  localparam int SRAM_DATA_W = 8;
  localparam int SRAM_ADDR_W = 3;
  localparam int SRAM_DEPTH  = 2 ** SRAM_ADDR_W;

  typedef enum logic {
    IDLE,
    RD_PEND
  } state_t;

endpackage

// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO over a single-port registered-read SRAM; first byte out 3 cycles after its write.
// in_ready drops when the SRAM is full or a read claims the port; reads stall while out_data is held.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W,
  parameter int ADDR_W = SRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH = CW'(2 ** ADDR_W);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   mem_cnt_q, mem_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              rd_issue;
  logic              wr_fire;
  logic              capture;

  // Reads own the port whenever the output register can take their data.
  assign rd_issue = (state_q == IDLE) && (mem_cnt_q != '0) && (!out_valid_q || out_ready);
  assign full     = (mem_cnt_q == DEPTH);
  assign in_ready = !full && !rd_issue;
  assign wr_fire  = in_valid && in_ready;
  assign capture  = (state_q == RD_PEND);

  assign mem_wr    = wr_fire;
  assign mem_rd    = rd_issue;
  assign mem_addr  = rd_issue ? rd_ptr_q : wr_ptr_q;
  assign mem_din   = in_data;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = mem_cnt_q + CW'(capture) + CW'(out_valid_q);
  assign empty     = (count == '0);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_cnt_d   = mem_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (rd_issue) begin
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      mem_cnt_d = mem_cnt_q - CW'(1);
      state_d   = RD_PEND;
    end else if (wr_fire) begin
      wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
      mem_cnt_d = mem_cnt_q + CW'(1);
    end

    if (capture) begin
      state_d     = IDLE;
      out_valid_d = 1'b1;
      out_data_d  = mem_dout;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural registered-read SRAM alongside it.
module tb_sram_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       mem_wr;
  logic       mem_rd;
  logic [2:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;

  logic [7:0] sram [8];
  logic [7:0] exp_q [$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wr_total = 0;
  int rd_total = 0;
  int last_pop = 0;
  bit have_last = 0;
  bit rate_chk  = 0;

  sram_fifo_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .mem_wr   (mem_wr),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_wr) sram[mem_addr] <= mem_din;
    if (mem_rd) mem_dout <= sram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Per-cycle monitor: port exclusivity, address sequencing, and output order.
  task automatic sample();
    #1;
    chk("wr_rd_exclusive", {31'b0, mem_wr & mem_rd}, 32'd0);
    chk("mem_wr_is_fire", {31'b0, mem_wr}, {31'b0, in_valid & in_ready});
    chk("mem_din", {24'b0, mem_din}, {24'b0, in_data});
    if (mem_wr) begin
      chk("wr_addr", {29'b0, mem_addr}, {29'b0, wr_total[2:0]});
      wr_total++;
    end
    if (mem_rd) begin
      chk("rd_addr", {29'b0, mem_addr}, {29'b0, rd_total[2:0]});
      rd_total++;
    end
    if (in_valid && in_ready) exp_q.push_back(in_data);
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL pop_unexpected: observed=0x%0h expected=none", out_data);
      end
      if (exp_q.size() != 0) chk("pop_data", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
      if (rate_chk) begin
        if (have_last) chk("pop_interval", cyc - last_pop, 32'd2);
        last_pop  = cyc;
        have_last = 1'b1;
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, {24'b0, out_data}, 32'd0);
    chk({tag, "_count"}, {28'b0, count}, 32'd0);
    chk({tag, "_full"}, {31'b0, full}, 32'd0);
    chk({tag, "_empty"}, {31'b0, empty}, 32'd1);
    chk({tag, "_mem_wr"}, {31'b0, mem_wr}, 32'd0);
    chk({tag, "_mem_rd"}, {31'b0, mem_rd}, 32'd0);
    chk({tag, "_mem_addr"}, {29'b0, mem_addr}, 32'd0);
  endtask

  initial begin
    bit accepted;
    int idx;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #2;
    chk_reset_vals("rst");
    tick();
    rst = 1'b0;

    // First word through an empty FIFO with the output stalled.
    in_valid = 1'b1;
    in_data  = 8'h3E;
    sample();
    chk("t1_in_ready", {31'b0, in_ready}, 32'd1);
    chk("t1_wr_addr0", {29'b0, mem_addr}, 32'd0);
    tick();
    in_valid = 1'b0;
    sample();
    chk("t1_mem_rd", {31'b0, mem_rd}, 32'd1);
    chk("t1_rd_addr0", {29'b0, mem_addr}, 32'd0);
    chk("t1_in_ready_blocked", {31'b0, in_ready}, 32'd0);
    chk("t1_count_c1", {28'b0, count}, 32'd1);
    tick();
    sample();
    chk("t1_out_valid_c2", {31'b0, out_valid}, 32'd0);
    chk("t1_count_c2", {28'b0, count}, 32'd1);
    tick();
    sample();
    chk("t1_out_valid_c3", {31'b0, out_valid}, 32'd1);
    chk("t1_out_data_c3", {24'b0, out_data}, 32'h3E);
    chk("t1_count_c3", {28'b0, count}, 32'd1);
    chk("t1_empty_c3", {31'b0, empty}, 32'd0);
    out_ready = 1'b1;
    sample();
    tick();
    out_ready = 1'b0;
    sample();
    chk("t1_drained_empty", {31'b0, empty}, 32'd1);
    chk("t1_drained_valid", {31'b0, out_valid}, 32'd0);
    tick();

    // Fill: nine bytes fit (eight in SRAM plus the output register).
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      accepted = 1'b0;
      for (int w = 0; w < 4 && !accepted; w++) begin
        sample();
        accepted = in_ready;
        tick();
      end
      chk("fill_accept", {31'b0, accepted}, 32'd1);
    end
    in_valid = 1'b1;
    in_data  = 8'h99;
    sample();
    chk("fill_full", {31'b0, full}, 32'd1);
    chk("fill_in_ready", {31'b0, in_ready}, 32'd0);
    chk("fill_count", {28'b0, count}, 32'd9);
    chk("fill_out_valid", {31'b0, out_valid}, 32'd1);
    chk("fill_out_data", {24'b0, out_data}, 32'h00);
    tick();
    in_valid = 1'b0;
    sample();
    chk("tenth_ignored_count", {28'b0, count}, 32'd9);
    tick();

    // Drain at one byte per two cycles.
    out_ready = 1'b1;
    rate_chk  = 1'b1;
    have_last = 1'b0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      sample();
      if (c == 0) chk("drain_full_c0", {31'b0, full}, 32'd1);
      if (c == 1) chk("drain_full_c1", {31'b0, full}, 32'd0);
      tick();
    end
    rate_chk = 1'b0;
    chk("drain_left", exp_q.size(), 32'd0);
    sample();
    chk("drain_empty", {31'b0, empty}, 32'd1);
    chk("drain_count", {28'b0, count}, 32'd0);
    chk("drain_out_valid", {31'b0, out_valid}, 32'd0);
    tick();

    // Stream 12 bytes through while reading; pointers wrap.
    idx = 0;
    for (int c = 0; c < 100 && (idx < 12 || exp_q.size() > 0 || out_valid); c++) begin
      in_valid = (idx < 12);
      in_data  = 8'(8'h40 + idx);
      sample();
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    chk("stream_in_done", idx, 32'd12);
    chk("stream_left", exp_q.size(), 32'd0);
    out_ready = 1'b0;
    sample();
    chk("stream_empty", {31'b0, empty}, 32'd1);
    tick();

    // Reset pulse while a read is pending.
    in_valid = 1'b1;
    in_data  = 8'h5A;
    sample();
    tick();
    in_valid = 1'b0;
    sample();
    chk("rp_mem_rd", {31'b0, mem_rd}, 32'd1);
    tick();
    sample();
    chk("rp_count_pending", {28'b0, count}, 32'd1);
    #1 rst = 1'b1;
    #1 chk_reset_vals("midrst");
    #1 rst = 1'b0;
    exp_q.delete();
    wr_total = 0;
    rd_total = 0;
    tick();
    sample();
    chk("rp_no_stale_valid", {31'b0, out_valid}, 32'd0);
    chk("rp_count_after", {28'b0, count}, 32'd0);
    tick();
    in_valid = 1'b1;
    in_data  = 8'hC7;
    sample();
    chk("rp_wr_addr0", {29'b0, mem_addr}, 32'd0);
    chk("rp_mem_wr", {31'b0, mem_wr}, 32'd1);
    tick();
    in_valid = 1'b0;
    sample();
    tick();
    sample();
    tick();
    sample();
    chk("rp_out_valid", {31'b0, out_valid}, 32'd1);
    chk("rp_out_data", {24'b0, out_data}, 32'hC7);
    out_ready = 1'b1;
    sample();
    tick();
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
